// File: rtl/mm_resp_pkg.sv
// Shared constants and types for the mm_resp memory-mapped responder:
// default address map, legal store widths and the address-region decode type.
package mm_resp_pkg;

  localparam logic [63:0] DEF_MEM_BASE    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DEF_TIMER_ADDR  = 64'h0000_0000_A000_0048;
  localparam logic [63:0] DEF_SERIAL_ADDR = 64'h0000_0000_A000_03F8;

  localparam logic [3:0] WLEN_B = 4'd1;
  localparam logic [3:0] WLEN_H = 4'd2;
  localparam logic [3:0] WLEN_W = 4'd4;
  localparam logic [3:0] WLEN_D = 4'd8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RAM,
    REG_TIMER,
    REG_SERIAL
  } region_e;

  function automatic logic wlen_legal(input logic [3:0] wlen);
    return (wlen == WLEN_B) || (wlen == WLEN_H) || (wlen == WLEN_W) || (wlen == WLEN_D);
  endfunction

endpackage

// File: rtl/mm_resp_if.sv
// Memory-mapped request/response bus plus the serial byte stream and error flag.
interface mm_resp_if;
  logic [63:0] mm_addr;
  logic [63:0] mm_wdata;
  logic [3:0]  mm_wlen;
  logic        mm_wen;
  logic        mm_ren;
  logic [63:0] mm_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  modport master (
    output mm_addr, mm_wdata, mm_wlen, mm_wen, mm_ren, tx_ready,
    input  mm_rdata, tx_data, tx_valid, err
  );

  modport slave (
    input  mm_addr, mm_wdata, mm_wlen, mm_wen, mm_ren, tx_ready,
    output mm_rdata, tx_data, tx_valid, err
  );
endinterface

// File: rtl/mm_txq.sv
// Byte FIFO feeding the serial output; a push into a full queue succeeds only
// when a pop happens in the same cycle. Head reads as 0 while empty.
module mm_txq #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [7:0]       i_data,
  input  logic             i_pop,
  output logic [7:0]       o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [7:0]       r_buf [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage arrays are left unreset; occupancy alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_wr_ptr] <= i_data;
  end

  assign o_data  = w_empty ? 8'h00 : r_buf[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/mm_resp.sv
// Memory-mapped responder: byte-lane RAM, free-running cycle timer and a
// serial output queue, with combinational loads and a sticky error flag.
module mm_resp
  import mm_resp_pkg::*;
#(
  parameter int          MEM_WORDS   = 256,
  parameter logic [63:0] MEM_BASE    = DEF_MEM_BASE,
  parameter logic [63:0] TIMER_ADDR  = DEF_TIMER_ADDR,
  parameter logic [63:0] SERIAL_ADDR = DEF_SERIAL_ADDR,
  parameter int          TXQ_DEPTH   = 4
) (
  input logic       clk,
  input logic       rst,
  mm_resp_if.slave  bus
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam int          CNT_W     = $clog2(TXQ_DEPTH) + 1;
  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 3;

  logic [63:0] r_mem [MEM_WORDS];
  logic [63:0] r_timer;
  logic        r_err;

  region_e          w_region;
  logic [63:0]      w_offset;
  logic [IDX_W-1:0] w_idx;
  logic [2:0]       w_off;
  logic [4:0]       w_end;
  logic             w_len_ok;
  logic [7:0]       w_lane_en;
  logic [63:0]      w_wdata_sh;
  logic             w_ram_we;
  logic             w_err_set;
  logic [63:0]      w_rdata;

  logic [7:0]       w_q_data;
  logic             w_q_full;
  logic             w_q_empty;
  logic [CNT_W-1:0] w_q_count;
  logic             w_q_push;
  logic             w_q_pop;

  assign w_offset = bus.mm_addr - MEM_BASE;
  assign w_idx    = w_offset[IDX_W+2:3];
  assign w_off    = bus.mm_addr[2:0];

  always_comb begin
    w_region = REG_NONE;
    if ((bus.mm_addr >= MEM_BASE) && (w_offset < MEM_BYTES)) w_region = REG_RAM;
    else if (bus.mm_addr == TIMER_ADDR)                      w_region = REG_TIMER;
    else if (bus.mm_addr == SERIAL_ADDR)                     w_region = REG_SERIAL;
  end

  // A RAM store must fit inside one doubleword starting at its byte offset.
  assign w_end      = 5'(w_off) + 5'(bus.mm_wlen);
  assign w_len_ok   = wlen_legal(bus.mm_wlen) && (w_end <= 5'd8);
  assign w_wdata_sh = bus.mm_wdata << {w_off, 3'b000};
  assign w_ram_we   = bus.mm_wen && (w_region == REG_RAM) && w_len_ok;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_lane_en = '0;
    for (int i = 0; i < 8; i++) begin
      w_lane_en[i] = (5'(i) >= 5'(w_off)) && (5'(i) < w_end);
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 8; i++) begin
        if (w_lane_en[i]) r_mem[w_idx][i*8 +: 8] <= w_wdata_sh[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_timer <= '0;
    else     r_timer <= r_timer + 64'd1;
  end

  assign w_q_pop  = !w_q_empty && bus.tx_ready;
  assign w_q_push = bus.mm_wen && (w_region == REG_SERIAL);

  mm_txq #(.DEPTH(TXQ_DEPTH)) u_txq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_q_push),
    .i_data  (bus.mm_wdata[7:0]),
    .i_pop   (w_q_pop),
    .o_data  (w_q_data),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_q_count)
  );

  always_comb begin
    w_err_set = 1'b0;
    if (bus.mm_wen) begin
      case (w_region)
        REG_RAM:    w_err_set = !w_len_ok;
        REG_SERIAL: w_err_set = w_q_full && !w_q_pop;
        default:    w_err_set = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | w_err_set;
  end

  always_comb begin
    w_rdata = '0;
    if (bus.mm_ren) begin
      case (w_region)
        REG_RAM:    w_rdata = r_mem[w_idx];
        REG_TIMER:  w_rdata = r_timer;
        REG_SERIAL: w_rdata = {56'b0, w_q_full, 3'b000, 4'(w_q_count)};
        default:    w_rdata = '0;
      endcase
    end
  end

  assign bus.mm_rdata = w_rdata;
  assign bus.tx_data  = w_q_data;
  assign bus.tx_valid = !w_q_empty;
  assign bus.err      = r_err;

endmodule
